// File: rtl/serial_accum_pkg.sv
// Shared types and helpers for the bit-serial accumulator.
package serial_accum_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_carry_cell.sv
// One-bit full-adder sum with a JK-form carry flip-flop; loadable carry-in for subtraction.
module serial_carry_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic init,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c_next,
  output logic c
);

  logic j, k;

  always_comb begin
    j      = a & b;
    k      = ~(a | b);
    s      = a ^ b ^ c;
    c_next = (j & ~c) | (~k & c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= 1'b0;
    end else if (clr) begin
      c <= 1'b0;
    end else if (load) begin
      c <= init;
    end else if (en) begin
      c <= c_next;
    end
  end

endmodule

// File: rtl/serial_accum.sv
// Bit-serial add/subtract accumulator, LSB first, valid/ready input and one-cycle done pulse.
module serial_accum
  import serial_accum_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic [WIDTH-1:0] acc,
  output logic             done,
  output logic             ovf
);

  if (WIDTH < 2) begin : gen_width_check
    $error("serial_accum: WIDTH must be at least 2");
  end

  localparam int unsigned CntW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] w_q, b_q, acc_q, w_shift;
  logic [CntW-1:0]  cnt_q;
  logic             mode_q, ovf_q;
  logic             accept, add_en, last;
  logic             s, c_next, c;

  always_comb begin
    accept  = in_valid & (state_q == StIdle) & ~clr;
    add_en  = (state_q == StAdd);
    last    = add_en && (cnt_q == CntW'(WIDTH - 1));
    w_shift = {s, w_q[WIDTH-1:1]};
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StAdd;
      StAdd:   if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand is inverted and carry-in preloaded with 1 so subtraction is acc + ~x + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (clr) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      w_q    <= acc_q;
      b_q    <= in_sub ? ~in_data : in_data;
      cnt_q  <= '0;
      mode_q <= in_sub;
    end else if (add_en) begin
      w_q   <= w_shift;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CntW'(1);
      if (last) begin
        acc_q <= w_shift;
        ovf_q <= mode_q ? ~c_next : c_next;
      end
    end
  end

  serial_carry_cell u_carry (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .load   (accept),
    .init   (in_sub),
    .en     (add_en),
    .a      (w_q[0]),
    .b      (b_q[0]),
    .s      (s),
    .c_next (c_next),
    .c      (c)
  );

  // The carry flop still holds the final carry-out while done is high.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == StDone) |-> (ovf_q == (c ^ mode_q)));

  assign in_ready = (state_q == StIdle);
  assign done     = (state_q == StDone);
  assign acc      = acc_q;
  assign ovf      = ovf_q;

endmodule
